// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: valid/ready issue front-end holding FP ALU inputs for a settle window, capturing result+flags into a drained output register, with sticky flags and op counter (ports: in_* upstream, alu_* ALU side, out_* downstream, sticky_*/busy/ops_count status)
module fpu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [3:0]       in_op,
  output logic [31:0]      alu_a_operand,
  output logic [31:0]      alu_b_operand,
  output logic [3:0]       alu_operation,
  input  logic [31:0]      alu_output,
  input  logic             alu_exception,
  input  logic             alu_overflow,
  input  logic             alu_underflow,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_exception,
  output logic             out_overflow,
  output logic             out_underflow,
  output logic             out_illegal,
  input  logic             sticky_clr,
  output logic [3:0]       sticky_flags,
  output logic             busy,
  output logic [CNT_W-1:0] ops_count
);
  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;
  localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [3:0] cnt;
  logic legal, accept, drain, capture;
  logic [3:0] cap_flags;
  assign legal = in_op[3:2] == 2'b00;
  assign in_ready = state == IDLE || (state == DONE && out_ready);
  assign accept = in_valid && in_ready;
  assign drain = state == DONE && out_ready;
  assign capture = (state == SETTLE && cnt == 4'd0) || (accept && !legal);
  assign cap_flags = state == SETTLE ? {1'b0, alu_underflow, alu_overflow, alu_exception} : 4'b1000;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = accept ? (legal ? SETTLE : DONE) :
              state == SETTLE ? (cnt == 4'd0 ? DONE : SETTLE) :
              drain ? IDLE : state;
  end
  always_ff @(posedge clk)
    if (rst) begin
      alu_a_operand <= '0;
      alu_b_operand <= '0;
      alu_operation <= '0;
      cnt           <= '0;
      out_result    <= '0;
      out_exception <= 1'b0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_illegal   <= 1'b0;
      sticky_flags  <= '0;
      ops_count     <= '0;
    end else begin
      if (accept) begin
        alu_a_operand <= in_a;
        alu_b_operand <= in_b;
        alu_operation <= legal ? in_op : 4'd0;
        cnt           <= CNT_LOAD;
      end else if (state == SETTLE && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (capture) begin
        out_result    <= state == SETTLE ? alu_output : 32'd0;
        out_exception <= cap_flags[0];
        out_overflow  <= cap_flags[1];
        out_underflow <= cap_flags[2];
        out_illegal   <= cap_flags[3];
      end
      sticky_flags <= (sticky_clr ? 4'd0 : sticky_flags) | (capture ? cap_flags : 4'd0);
      if (drain) ops_count <= ops_count + 1'b1;
    end
endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed + random check of fpu_issue_ctrl against a transaction-queue model with a settling fake ALU
module tb_fpu_issue_ctrl;
  localparam int S = 2;
  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          ready;
  } exp_t;
  logic clk = 1'b0;
  logic rst, in_valid, out_ready, sticky_clr;
  logic [31:0] in_a, in_b;
  logic [3:0] in_op;
  logic in_ready, out_valid, busy;
  logic [31:0] alu_a_operand, alu_b_operand, alu_output, out_result;
  logic [3:0] alu_operation, sticky_flags;
  logic alu_exception, alu_overflow, alu_underflow;
  logic out_exception, out_overflow, out_underflow, out_illegal;
  logic [15:0] ops_count;
  int total = 0;
  int bad = 0;
  int cycle = 0;
  int age = 0;
  logic [67:0] prev_alu = '0;
  logic [34:0] fn_now;
  exp_t q[$];
  logic [3:0] sticky_m = '0;
  logic [15:0] ops_m = '0;
  logic [31:0] alu_a_m = '0, alu_b_m = '0;
  logic [3:0] alu_op_m = '0;
  bit last_acc;
  logic [31:0] vals [3] = '{32'h3F800000, 32'h40000000, 32'h40400000};

  fpu_issue_ctrl #(.SETTLE_CYCLES(S), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a_operand(alu_a_operand), .alu_b_operand(alu_b_operand), .alu_operation(alu_operation),
    .alu_output(alu_output), .alu_exception(alu_exception), .alu_overflow(alu_overflow),
    .alu_underflow(alu_underflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_exception(out_exception), .out_overflow(out_overflow),
    .out_underflow(out_underflow), .out_illegal(out_illegal), .sticky_clr(sticky_clr),
    .sticky_flags(sticky_flags), .busy(busy), .ops_count(ops_count)
  );

  always #5 clk = ~clk;

  function automatic logic [34:0] alu_fn(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    logic [31:0] r;
    logic ex, of, uf;
    if (a == 32'h3F800000 && b == 32'h40000000 && op == 4'd0) r = 32'h40400000;
    else if (a == 32'h40000000 && b == 32'h40400000 && op == 4'd2) r = 32'h40C00000;
    else r = (a + {b[15:0], b[31:16]}) ^ {28'h0, op} ^ 32'h5A5A0000;
    ex = a[30:23] == 8'hFF || b[30:23] == 8'hFF;
    of = r[31] & r[3];
    uf = r[30] & ~r[2] & r[7];
    return {uf, of, ex, r};
  endfunction

  // fake ALU: output is garbage until its inputs have been stable for S-1 negedges
  always @(negedge clk)
    if ({alu_a_operand, alu_b_operand, alu_operation} !== prev_alu) begin
      prev_alu <= {alu_a_operand, alu_b_operand, alu_operation};
      age <= 0;
    end else if (age < 15) age <= age + 1;
  assign fn_now = alu_fn(alu_a_operand, alu_b_operand, alu_operation);
  assign alu_output = age >= S - 1 ? fn_now[31:0] : 32'hDEADBEEF;
  assign alu_exception = age >= S - 1 ? fn_now[32] : 1'b1;
  assign alu_overflow = age >= S - 1 ? fn_now[33] : 1'b1;
  assign alu_underflow = age >= S - 1 ? fn_now[34] : 1'b1;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic ov, ir;
    logic [34:0] f;
    exp_t e;
    #1;
    ov = q.size() > 0 && cycle >= q[0].ready;
    ir = q.size() == 0 || (ov && out_ready);
    chk("out_valid", 32'(out_valid), 32'(ov));
    chk("in_ready", 32'(in_ready), 32'(ir));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("ops_count", 32'(ops_count), 32'(ops_m));
    chk("sticky", 32'(sticky_flags), 32'(sticky_m));
    chk("alu_a", alu_a_operand, alu_a_m);
    chk("alu_b", alu_b_operand, alu_b_m);
    chk("alu_op", 32'(alu_operation), 32'(alu_op_m));
    last_acc = 0;
    if (!rst) begin
      if (ov && out_ready) begin
        e = q.pop_front();
        chk("out_result", out_result, e.res);
        chk("out_flags", 32'({out_illegal, out_underflow, out_overflow, out_exception}), 32'(e.fl));
        ops_m++;
      end
      if (in_valid && ir) begin
        if (in_op < 4'd4) begin
          f = alu_fn(in_a, in_b, in_op);
          e.res = f[31:0];
          e.fl = {1'b0, f[34:32]};
          e.ready = cycle + 1 + S;
          alu_op_m = in_op;
        end else begin
          e.res = '0;
          e.fl = 4'b1000;
          e.ready = cycle + 1;
          alu_op_m = '0;
        end
        alu_a_m = in_a;
        alu_b_m = in_b;
        q.push_back(e);
        last_acc = 1;
      end
    end
    @(posedge clk);
    cycle++;
    if (rst) begin
      q.delete();
      sticky_m = '0;
      ops_m = '0;
      alu_a_m = '0;
      alu_b_m = '0;
      alu_op_m = '0;
    end else
      sticky_m = (sticky_clr ? 4'd0 : sticky_m) | ((q.size() > 0 && q[0].ready == cycle) ? q[0].fl : 4'd0);
    @(negedge clk);
  endtask

  task automatic issue(logic [31:0] a, logic [31:0] b, logic [3:0] op);
    in_a = a;
    in_b = b;
    in_op = op;
    in_valid = 1;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    rst = 1; in_valid = 0; out_ready = 0; sticky_clr = 0;
    in_a = '0; in_b = '0; in_op = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("rst_result", out_result, 32'd0);
    chk("rst_flags", 32'({out_illegal, out_underflow, out_overflow, out_exception}), 32'd0);
    out_ready = 1;
    issue(32'h3F800000, 32'h40000000, 4'd0);
    repeat (3) cyc();
    chk("add_ops", 32'(ops_count), 32'd1);
    out_ready = 0;
    issue(32'h40000000, 32'h40400000, 4'd2);
    repeat (7) cyc();
    chk("mul_hold", out_result, 32'h40C00000);
    out_ready = 1;
    repeat (2) cyc();
    issue(32'h7F800000, 32'h40000000, 4'd2);
    repeat (3) cyc();
    issue(32'h3F800000, 32'h40000000, 4'd0);
    repeat (3) cyc();
    chk("sticky_persist", 32'(sticky_flags[0]), 32'd1);
    sticky_clr = 1;
    cyc();
    sticky_clr = 0;
    cyc();
    issue(32'h7F800000, 32'h40000000, 4'd2);
    cyc();
    sticky_clr = 1;
    cyc();
    sticky_clr = 0;
    chk("clr_vs_capture", 32'(sticky_flags[0]), 32'd1);
    repeat (2) cyc();
    issue(32'h12345678, 32'h9ABCDEF0, 4'd7);
    chk("illegal_result", out_result, 32'd0);
    chk("illegal_flag", 32'(out_illegal), 32'd1);
    repeat (2) cyc();
    rst = 1; cyc(); rst = 0;
    for (int i = 0; i < 3; i++) begin
      in_a = vals[i]; in_b = 32'h40000000; in_op = 4'd0; in_valid = 1;
      for (int j = 0; j < 20; j++) begin
        cyc();
        if (last_acc) break;
      end
    end
    in_valid = 0;
    repeat (3) cyc();
    chk("b2b_ops", 32'(ops_count), 32'd3);
    issue(32'h3F800000, 32'h40000000, 4'd1);
    rst = 1; cyc(); rst = 0;
    repeat (4) cyc();
    chk("rst_mid_result", out_result, 32'd0);
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom % 3 != 0;
      in_a = ($urandom % 5 == 0) ? 32'h7F800000 : $urandom;
      in_b = $urandom;
      in_op = ($urandom % 4 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom % 4);
      out_ready = $urandom % 4 != 0;
      sticky_clr = $urandom % 10 == 0;
      rst = $urandom % 60 == 0;
      cyc();
    end
    rst = 0; in_valid = 0; out_ready = 1; sticky_clr = 0;
    repeat (4) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
